data_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port, byte-addressed data memory between `N_REQ` requesters, such as the CPU load/store unit and a debug/DMA port. It accepts one request at a time and drives the memory's write-enable, store-width, load-width, address and write-data controls for exactly one cycle. It registers the read data and returns it with a one-cycle `rvalid` pulse to the granted requester. It sits between the requesters and the data memory and is the only driver of the memory port.

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/rr_picker.sv | 26 ++
 rtl/data_mem_arbiter.sv | 91 +++++++++
 tb/tb_data_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: arbiter state encoding and latched request record for data_mem_arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef struct packed {
        logic        we;
        logic        byte_op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational one-hot round-robin select, searching upward from ptr_i+1 modulo N_REQ.
module rr_picker #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] idx_o
);
    localparam int PW = $clog2(N_REQ);
    logic [PW-1:0] w_k;
    // Walk from the farthest candidate to the nearest so the nearest hit is the last write.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        w_k   = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            w_k = PW'((int'(ptr_i) + i) % N_REQ);
            if (req_i[w_k]) begin
                gnt_o      = '0;
                gnt_o[w_k] = 1'b1;
                idx_o      = w_k;
            end
        end
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin sharing of one byte-addressed data memory port among N_REQ requesters.
// Define MEM_ARB_ALIGN_CHECK_EN to suppress misaligned word accesses and flag them with err_o.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_i,
    input  logic [N_REQ-1:0]  we_i,
    input  logic [N_REQ-1:0]  byte_i,
    input  logic [ADDR_W-1:0] addr_i [N_REQ],
    input  logic [31:0]       wdata_i [N_REQ],
    output logic [N_REQ-1:0]  gnt_o,
    output logic [N_REQ-1:0]  rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              mem_we_o,
    output logic              mem_stsrc_o,
    output logic              mem_ldsrc_o,
    output logic [31:0]       mem_addr_o,
    output logic [31:0]       mem_wd_o,
    input  logic [31:0]       mem_rd_i
);
    localparam int PW = $clog2(N_REQ);
    state_t           r_state;
    req_t             r_req;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_idx;
    logic [PW-1:0]    w_idx;
    logic [N_REQ-1:0] w_pick;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic             w_issue;
    logic             w_resp;
    logic             w_mis;

    rr_picker #(.N_REQ(N_REQ)) u_pick (
        .req_i (req_i),
        .ptr_i (r_ptr),
        .gnt_o (w_pick),
        .idx_o (w_idx)
    );

`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign w_mis = !r_req.byte_op && (r_req.addr[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    assign w_issue     = r_state == ISSUE;
    assign w_resp      = r_state == RESP;
    assign gnt_o       = w_issue ? '0 : w_pick;
    // Port outputs decode the state directly so an async reset drops the write strobe at once.
    assign mem_we_o    = w_issue & r_req.we & !w_mis;
    assign mem_stsrc_o = w_issue & r_req.byte_op;
    assign mem_ldsrc_o = w_issue & r_req.byte_op;
    assign mem_addr_o  = w_issue ? r_req.addr : '0;
    assign mem_wd_o    = w_issue ? r_req.wdata : '0;
    assign rvalid_o    = w_resp ? N_REQ'(1) << r_idx : '0;
    assign err_o       = w_resp & r_err;
    assign rdata_o     = r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= PW'(N_REQ - 1);
            r_idx   <= '0;
            r_req   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (|gnt_o) begin
                r_ptr <= w_idx;
                r_idx <= w_idx;
                r_req <= '{we: we_i[w_idx], byte_op: byte_i[w_idx],
                           addr: 32'(addr_i[w_idx]), wdata: wdata_i[w_idx]};
            end
            case (r_state)
                ISSUE: begin
                    r_state <= RESP;
                    r_rdata <= (r_req.we || w_mis) ? '0 : mem_rd_i;
                    r_err   <= w_mis;
                end
                default: r_state <= (|req_i) ? ISSUE : IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and randomized transactions against a transaction-level memory/arbiter model.
module tb_data_mem_arbiter;
    localparam int N = 2;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req_i = '0;
    logic [N-1:0] we_i = '0;
    logic [N-1:0] byte_i = '0;
    logic [31:0]  addr_i [N];
    logic [31:0]  wdata_i [N];
    logic [N-1:0] gnt_o, rvalid_o;
    logic [31:0]  rdata_o, mem_addr_o, mem_wd_o, mem_rd_i;
    logic         err_o, mem_we_o, mem_stsrc_o, mem_ldsrc_o;
    logic [7:0]   mem [256];
    logic [7:0]   ref_mem [256];
    logic [7:0]   init_val [256];
    logic [7:0]   ma;
    logic         init_mem = 1'b0;
    int           n_tests = 0;
    int           n_fail = 0;
    int           last = N - 1;
    bit           pend = 1'b0;
    int           exp_idx;
    logic [31:0]  exp_rd;
    logic         exp_err;
    logic [N-1:0] g_obs;

    always #5 clk = ~clk;

    data_mem_arbiter #(.N_REQ(N), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .we_i        (we_i),
        .byte_i      (byte_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .mem_we_o    (mem_we_o),
        .mem_stsrc_o (mem_stsrc_o),
        .mem_ldsrc_o (mem_ldsrc_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wd_o    (mem_wd_o),
        .mem_rd_i    (mem_rd_i)
    );

    // Little-endian byte memory, 256-byte window mirrored over the address space.
    assign ma = mem_addr_o[7:0];
    always_comb mem_rd_i = mem_ldsrc_o ? {24'h0, mem[ma]}
                                       : {mem[ma+8'd3], mem[ma+8'd2], mem[ma+8'd1], mem[ma]};
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val[i];
        end else if (mem_we_o) begin
            mem[ma] <= mem_wd_o[7:0];
            if (!mem_stsrc_o) begin
                mem[ma+8'd1] <= mem_wd_o[15:8];
                mem[ma+8'd2] <= mem_wd_o[23:16];
                mem[ma+8'd3] <= mem_wd_o[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [7:0] o);
        return {ref_mem[o+8'd3], ref_mem[o+8'd2], ref_mem[o+8'd1], ref_mem[o]};
    endfunction

    function automatic logic misaligned(input logic b, input logic [31:0] ad);
`ifdef MEM_ARB_ALIGN_CHECK_EN
        return !b && (ad[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int mem_diff();
        int d = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) d++;
        return d;
    endfunction

    task automatic set_req(input int r, input logic we, input logic b, input logic [31:0] ad, input logic [31:0] wd);
        we_i[r] = we;
        byte_i[r] = b;
        addr_i[r] = ad;
        wdata_i[r] = wd;
    endtask

    task automatic scramble();
        for (int r = 0; r < N; r++)
            set_req(r, 1'($urandom), 1'($urandom), 32'h10000 + 32'($urandom_range(0, 240)), $urandom);
    endtask

    task automatic check_resp();
        if (pend) begin
            chk("rvalid", 32'(rvalid_o), 32'(1) << exp_idx);
            chk("rdata", rdata_o, exp_rd);
            chk("err", 32'(err_o), 32'(exp_err));
            pend = 1'b0;
        end else begin
            chk("rvalid_quiet", 32'(rvalid_o), 32'h0);
        end
    endtask

    task automatic idle();
        check_resp();
        req_i = '0;
        @(posedge clk); #1;
    endtask

    // One transaction: entered #1 after an edge in IDLE or RESP, left #1 after the edge into RESP.
    task automatic run(input logic [N-1:0] mask, input logic [N-1:0] hold);
        int w = -1;
        logic [31:0] ad, wd;
        logic we, b, m;
        check_resp();
        req_i = mask;
        #1;
        for (int k = 1; k <= N && w < 0; k++) if (mask[(last + k) % N]) w = (last + k) % N;
        g_obs = gnt_o;
        chk("gnt", 32'(gnt_o), 32'(1) << w);
        last = w;
        we = we_i[w];
        b = byte_i[w];
        ad = addr_i[w];
        wd = wdata_i[w];
        m = misaligned(b, ad);
        exp_idx = w;
        exp_err = m;
        exp_rd = (we || m) ? 32'h0 : b ? {24'h0, ref_mem[ad[7:0]]} : ref_word(ad[7:0]);
        if (we && !m) begin
            ref_mem[ad[7:0]] = wd[7:0];
            if (!b) begin
                ref_mem[ad[7:0]+8'd1] = wd[15:8];
                ref_mem[ad[7:0]+8'd2] = wd[23:16];
                ref_mem[ad[7:0]+8'd3] = wd[31:24];
            end
        end
        @(posedge clk); #1;
        req_i = hold;
        scramble();
        chk("gnt_in_issue", 32'(gnt_o), 32'h0);
        chk("mem_we", 32'(mem_we_o), 32'(we && !m));
        chk("mem_src", 32'({mem_stsrc_o, mem_ldsrc_o}), 32'({b, b}));
        chk("mem_addr", mem_addr_o, ad);
        if (we) chk("mem_wd", mem_wd_o, wd);
        @(posedge clk); #1;
        pend = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) init_val[i] = 8'($urandom);
        init_val[0] = 8'h11;
        init_val[1] = 8'h22;
        init_val[2] = 8'h33;
        init_val[3] = 8'h44;
        ref_mem = init_val;
        scramble();
        init_mem = 1'b1;
        @(posedge clk); #1;
        init_mem = 1'b0;
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_rvalid", 32'(rvalid_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_mem_ctl", 32'({mem_we_o, mem_stsrc_o, mem_ldsrc_o}), 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_wd", mem_wd_o, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        set_req(0, 1'b0, 1'b0, 32'h10000, 32'h0);
        run(2'b01, 2'b00);
        chk("lw_gnt", 32'(g_obs), 32'h1);
        chk("lw_rdata", rdata_o, 32'h44332211);
        idle();

        set_req(1, 1'b1, 1'b1, 32'h10004, 32'h123456A5);
        run(2'b10, 2'b00);
        set_req(1, 1'b0, 1'b1, 32'h10004, 32'h0);
        run(2'b10, 2'b00);
        chk("lbu_rdata", rdata_o, 32'h000000A5);
        idle();

        set_req(0, 1'b1, 1'b0, 32'h10020, 32'hDEADBEEF);
        req_i = 2'b01;
        #1;
        chk("rst_mid_gnt", 32'(gnt_o), 32'h1);
        @(posedge clk); #1;
        req_i = '0;
        chk("rst_mid_we_before", 32'(mem_we_o), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we_abort", 32'(mem_we_o), 32'h0);
        chk("rst_mid_addr", mem_addr_o, 32'h0);
        @(posedge clk); #1;
        chk("rst_mid_rvalid", 32'(rvalid_o), 32'h0);
        rst_n = 1'b1;
        last = N - 1;
        pend = 1'b0;
        chk("rst_mid_mem", 32'(mem_diff()), 32'h0);
        idle();
        idle();

        for (int i = 0; i < 8; i++) begin
            run(2'b11, 2'b11);
            chk("contention_gnt", 32'(g_obs), (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        idle();

        set_req(1, 1'b1, 1'b0, 32'h10002, 32'hCAFEF00D);
        run(2'b10, 2'b00);
`ifdef MEM_ARB_ALIGN_CHECK_EN
        chk("mis_err", 32'(err_o), 32'h1);
        chk("mis_rdata", rdata_o, 32'h0);
`endif
        idle();
`ifdef MEM_ARB_ALIGN_CHECK_EN
        chk("mis_mem", 32'({mem[4], mem[3], mem[2]}), 32'h00A54433);
`else
        chk("mis_mem", {mem[5], mem[4], mem[3], mem[2]}, 32'hCAFEF00D);
`endif

        for (int i = 0; i < 60; i++) begin
            scramble();
            run(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
        idle();
        chk("final_mem", 32'(mem_diff()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
